// File: rtl/reg_bank_writer_pkg.sv
// Shared definitions for the register-bank writer: data/bank geometry and FSM encoding.
package reg_bank_writer_pkg;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NREG  = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic {
      StIdle  = 1'b0,
      StClear = 1'b1
   } state_e;

endpackage

// File: rtl/reg_bank_writer_dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable, used to steer bank writes.
module dec3to8
   import reg_bank_writer_pkg::*;
(
   input  logic             en,
   input  logic [IDX_W-1:0] sel,
   output logic [NREG-1:0]  onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/reg_bank_writer.sv
// Eight-entry register bank with per-register pending flags, sticky write error and
// a seven-cycle sweep-clear of entries 1..7 (entry 0 is hardwired to zero).
module reg_bank_writer #(
   parameter int unsigned WIDTH = reg_bank_writer_pkg::WIDTH,
   parameter int unsigned NREG  = reg_bank_writer_pkg::NREG
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [2:0]       wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rsv_valid,
   input  logic [2:0]       rsv_sel,
   input  logic             clr_req,
   output logic             clr_busy,
   output logic [WIDTH-1:0] reg0,
   output logic [WIDTH-1:0] reg1,
   output logic [WIDTH-1:0] reg2,
   output logic [WIDTH-1:0] reg3,
   output logic [WIDTH-1:0] reg4,
   output logic [WIDTH-1:0] reg5,
   output logic [WIDTH-1:0] reg6,
   output logic [WIDTH-1:0] reg7,
   output logic [NREG-1:0]  busy,
   output logic             wr_err
);

   import reg_bank_writer_pkg::*;

   localparam logic [IDX_W-1:0] PtrFirst = IDX_W'(1);
   localparam logic [IDX_W-1:0] PtrLast  = IDX_W'(NREG - 1);

   state_e                       state_q, state_d;
   logic [IDX_W-1:0]             ptr_q, ptr_d;
   logic [NREG-1:0][WIDTH-1:0]   regs_q, regs_d;
   logic [NREG-1:0]              busy_q, busy_d;
   logic                         wr_err_q, wr_err_d;
   logic [NREG-1:0]              wr_hot;
   logic                         wr_fire;

   assign wr_ready = (state_q == StIdle);
   assign clr_busy = (state_q == StClear);
   assign wr_fire  = wr_valid & wr_ready;

   dec3to8 u_dec (
      .en     (wr_fire),
      .sel    (wr_sel),
      .onehot (wr_hot)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      regs_d   = regs_q;
      busy_d   = busy_q;
      wr_err_d = wr_err_q;

      unique case (state_q)
         StIdle: begin
            for (int i = 1; i < int'(NREG); i++) begin
               if (wr_hot[i]) begin
                  regs_d[i] = wr_data;
                  busy_d[i] = 1'b0;
                  if (!busy_q[i]) begin
                     wr_err_d = 1'b1;
                  end
               end
            end
            if (clr_req) begin
               state_d = StClear;
               ptr_d   = PtrFirst;
            end
         end
         StClear: begin
            regs_d[ptr_q] = '0;
            busy_d[ptr_q] = 1'b0;
            if (ptr_q == PtrLast) begin
               state_d = StIdle;
               ptr_d   = PtrFirst;
            end else begin
               ptr_d = ptr_q + IDX_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Reservation is applied last so it overrides both write and sweep clears.
      if (rsv_valid) begin
         busy_d[rsv_sel] = 1'b1;
      end

      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         ptr_q    <= PtrFirst;
         regs_q   <= '0;
         busy_q   <= '0;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         regs_q   <= regs_d;
         busy_q   <= busy_d;
         wr_err_q <= wr_err_d;
      end
   end

   assign reg0   = regs_q[0];
   assign reg1   = regs_q[1];
   assign reg2   = regs_q[2];
   assign reg3   = regs_q[3];
   assign reg4   = regs_q[4];
   assign reg5   = regs_q[5];
   assign reg6   = regs_q[6];
   assign reg7   = regs_q[7];
   assign busy   = busy_q;
   assign wr_err = wr_err_q;

endmodule

// File: tb/tb_reg_bank_writer.sv
// Directed self-checking bench for reg_bank_writer: writes, reservations, sweep and reset.
module tb_reg_bank_writer;

   logic        clk;
   logic        rst_n;
   logic        wr_valid;
   logic        wr_ready;
   logic [2:0]  wr_sel;
   logic [15:0] wr_data;
   logic        rsv_valid;
   logic [2:0]  rsv_sel;
   logic        clr_req;
   logic        clr_busy;
   logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
   logic [7:0]  busy;
   logic        wr_err;
   logic [15:0] regs_w [8];

   int n_checks = 0;
   int n_errs   = 0;
   int n;

   reg_bank_writer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .rsv_valid (rsv_valid),
      .rsv_sel   (rsv_sel),
      .clr_req   (clr_req),
      .clr_busy  (clr_busy),
      .reg0      (reg0),
      .reg1      (reg1),
      .reg2      (reg2),
      .reg3      (reg3),
      .reg4      (reg4),
      .reg5      (reg5),
      .reg6      (reg6),
      .reg7      (reg7),
      .busy      (busy),
      .wr_err    (wr_err)
   );

   assign regs_w[0] = reg0;
   assign regs_w[1] = reg1;
   assign regs_w[2] = reg2;
   assign regs_w[3] = reg3;
   assign regs_w[4] = reg4;
   assign regs_w[5] = reg5;
   assign regs_w[6] = reg6;
   assign regs_w[7] = reg7;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [2:0] sel, input logic [15:0] data);
      wr_valid = 1'b1;
      wr_sel   = sel;
      wr_data  = data;
      cycle();
      wr_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_reg%0d", tag, i), 32'(regs_w[i]), 32'h0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      wr_valid  = 1'b0;
      wr_sel    = 3'd0;
      wr_data   = 16'h0;
      rsv_valid = 1'b0;
      rsv_sel   = 3'd0;
      clr_req   = 1'b0;
      #2;
      check_all_zero("reset");
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_wr_err", 32'(wr_err), 32'h0);
      check("reset_clr_busy", 32'(clr_busy), 32'h0);
      check("reset_wr_ready", 32'(wr_ready), 32'h1);
      #10;
      rst_n = 1'b1;
      cycle();

      // Reserve then write back
      rsv_valid = 1'b1;
      rsv_sel   = 3'd3;
      cycle();
      rsv_valid = 1'b0;
      check("rsv3_busy", 32'(busy), 32'h08);
      write(3'd3, 16'hBEEF);
      check("wr3_reg3", 32'(reg3), 32'hBEEF);
      check("wr3_busy", 32'(busy), 32'h00);
      check("wr3_wr_err", 32'(wr_err), 32'h0);

      // Index 0 is discarded
      wr_sel = 3'd0;
      check("wr0_ready", 32'(wr_ready), 32'h1);
      write(3'd0, 16'h1234);
      check("wr0_reg0", 32'(reg0), 32'h0);
      check("wr0_busy", 32'(busy), 32'h00);
      check("wr0_wr_err", 32'(wr_err), 32'h0);

      // Reserve and write same index in one cycle: reserve wins
      rsv_valid = 1'b1;
      rsv_sel   = 3'd5;
      cycle();
      check("rsv5_busy", 32'(busy), 32'h20);
      write(3'd5, 16'h00FF);
      rsv_valid = 1'b0;
      check("rsvwr5_reg5", 32'(reg5), 32'h00FF);
      check("rsvwr5_busy", 32'(busy), 32'h20);
      check("rsvwr5_wr_err", 32'(wr_err), 32'h0);

      // Write to non-pending register sets sticky error
      write(3'd2, 16'h0001);
      check("wr2_reg2", 32'(reg2), 32'h0001);
      check("wr2_wr_err", 32'(wr_err), 32'h1);
      cycle();
      cycle();
      cycle();
      check("wr_err_sticky", 32'(wr_err), 32'h1);

      // Fill reg1..reg7 with 1111..7777
      for (int i = 1; i < 8; i++) begin
         write(3'(i), 16'(16'h1111 * i));
      end
      check("fill_reg1", 32'(reg1), 32'h1111);
      check("fill_reg3", 32'(reg3), 32'h3333);
      check("fill_reg7", 32'(reg7), 32'h7777);
      check("fill_busy", 32'(busy), 32'h00);

      // Sweep with a stalled write, a reserve on the swept index and an ignored clr_req
      clr_req = 1'b1;
      cycle();
      clr_req  = 1'b0;
      wr_valid = 1'b1;
      wr_sel   = 3'd4;
      wr_data  = 16'hAAAA;
      n = 0;
      while (clr_busy && n < 20) begin
         check($sformatf("sweep_ready_c%0d", n), 32'(wr_ready), 32'h0);
         rsv_valid = (n == 2);
         rsv_sel   = 3'd3;
         clr_req   = (n == 4);
         cycle();
         n++;
      end
      rsv_valid = 1'b0;
      clr_req   = 1'b0;
      check("sweep_cycles", 32'(n), 32'd7);
      check("sweep_done_clr_busy", 32'(clr_busy), 32'h0);
      check("sweep_done_ready", 32'(wr_ready), 32'h1);
      check_all_zero("sweep");
      check("sweep_busy_rsv3", 32'(busy), 32'h08);
      cycle();
      wr_valid = 1'b0;
      check("stall_reg4", 32'(reg4), 32'hAAAA);
      check("stall_reg3", 32'(reg3), 32'h0);
      check("stall_busy", 32'(busy), 32'h08);

      // Reset in the middle of a sweep
      write(3'd6, 16'h6666);
      check("pre_rst_reg6", 32'(reg6), 32'h6666);
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      cycle();
      cycle();
      check("mid_sweep_clr_busy", 32'(clr_busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check("rst_clr_busy", 32'(clr_busy), 32'h0);
      check("rst_wr_ready", 32'(wr_ready), 32'h1);
      check_all_zero("rst");
      check("rst_busy", 32'(busy), 32'h00);
      check("rst_wr_err", 32'(wr_err), 32'h0);
      #1;
      rst_n = 1'b1;
      cycle();
      write(3'd1, 16'h5A5A);
      check("post_rst_reg1", 32'(reg1), 32'h5A5A);
      check("post_rst_wr_err", 32'(wr_err), 32'h1);
      check("post_rst_clr_busy", 32'(clr_busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_bank_writer.md
REG_BANK_WRITER -- requirements
Module: reg_bank_writer

Interface
REQ-001 SHALL have one clock and one asynchronous active-low reset: clk and rst_n.
REQ-002 Ports, listed as name, direction, width, meaning:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
REQ-003 Write port:
- wr_valid, input, 1, write request.
- wr_ready, output, 1, request accepted this cycle.
- wr_sel, input, 3, destination register index.
- wr_data, input, 16, write data.
REQ-004 Reservation port:
- rsv_valid, input, 1, mark register pending.
- rsv_sel, input, 3, register to reserve.
REQ-005 Clear port:
- clr_req, input, 1, start sweep-clear of the bank.
- clr_busy, output, 1, sweep in progress.
REQ-006 Bank outputs:
- reg0..reg7, output, 16 each, registered bank contents; these drive the 8-input read selector.
- busy, output, 8, per-register pending flags.
- wr_err, output, 1, sticky: a write hit a non-pending register.
REQ-007 Parameters, listed as name, default, meaning: WIDTH, 16, data width; NREG, 8, register count (fixed at 8, sel width 3).

Function
REQ-008 A write transfer SHALL occur on a rising edge where wr_valid and wr_ready are both 1.
REQ-009 An accepted write SHALL update reg[wr_sel] so the new value is visible on the next cycle (latency 1); no other register changes.
REQ-010 reg0 SHALL read 0 at all times; writes to index 0 are accepted but discarded, and busy[0] never sets.
REQ-011 wr_ready SHALL be 1 in IDLE and 0 in CLEAR.
REQ-012 rsv_valid SHALL set busy[rsv_sel] on the next edge; it is honoured in both states.
REQ-013 An accepted write SHALL clear busy[wr_sel] on the next edge.
REQ-014 If a reserve and an accepted write target the same index in one cycle, the register SHALL take the data and busy SHALL end at 1 (reserve wins).
REQ-015 An accepted write to index 1..7 whose busy bit is 0 SHALL still commit and SHALL set wr_err; wr_err clears only on reset.
REQ-016 FSM states SHALL be IDLE and CLEAR.
- IDLE to CLEAR: clr_req=1, clearing ptr to 1.
- CLEAR: each cycle zeroes reg[ptr] and clears busy[ptr], then ptr+1.
- CLEAR to IDLE: after ptr=7 is cleared; the sweep lasts 7 cycles.
REQ-017 clr_busy SHALL be 1 exactly while in CLEAR.
REQ-018 clr_req SHALL be ignored while in CLEAR; there is no restart.
REQ-019 A write presented during CLEAR SHALL be held off: wr_ready is 0, and the requester keeps wr_valid and its data stable.
REQ-020 A reservation landing in CLEAR on the index being swept in that cycle SHALL leave busy=1 (reserve wins).
REQ-021 The pointer SHALL be 3 bits and SHALL not wrap past 7 within a sweep.

Reset
REQ-022 On rst_n=0, immediately and regardless of clk: reg0..reg7=0, busy=0, wr_err=0, state=IDLE, ptr=1, clr_busy=0, wr_ready=1.
REQ-023 Reset asserted mid-sweep SHALL abort the sweep; the block returns to IDLE with all registers 0.
REQ-024 After rst_n deasserts, the first accepted write SHALL occur no earlier than the first rising edge.

Structure
REQ-025 The shared datapath package SHALL hold WIDTH, NREG, the state encoding (IDLE=0, CLEAR=1) and the register-index width.
REQ-026 The 3-to-8 one-hot write decoder SHALL be a sub-module named dec3to8, combinational, with an enable input.
REQ-027 All state SHALL sit in a single always block sensitive to posedge clk and negedge rst_n; the outputs are direct register outputs.

Verification
REQ-028 Write then read back: reserve 3, then write sel=3, data=16'hBEEF → next cycle reg3=BEEF, busy[3]=0, wr_err=0.
REQ-029 Write to index 0: write sel=0, data=16'h1234 → reg0 stays 0, wr_ready=1, busy unchanged.
REQ-030 Simultaneous reserve and write: rsv_sel=5 and write sel=5, data=16'h00FF in one cycle → reg5=00FF, busy[5]=1.
REQ-031 Write to a non-pending register: write sel=2, data=16'h0001 with busy[2]=0 → reg2=0001 and wr_err=1, held until reset.
REQ-032 Sweep with a stalled write: fill reg1..reg7 with nonzero values, pulse clr_req, and hold wr_valid with sel=4, data=16'hAAAA:
- clr_busy=1 for 7 cycles, wr_ready=0 throughout, all registers reach 0.
- The write then commits, giving reg4=AAAA.
REQ-033 Reset mid-sweep: drop rst_n at sweep cycle 3 → clr_busy=0 asynchronously, all registers 0, busy=0, and normal writes resume afterwards.
